// File: rtl/input_pkg.sv
// Shared definitions for the button input front end.
//   rpt_state_e      : per-channel auto-repeat state encoding
//   DEBOUNCE_100MHZ  : 5 ms stability window at the 100 MHz board clock
//   max_u()          : elaboration-time maximum of two unsigned values
package input_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEBOUNCE_100MHZ = 32'd500000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, stability-window debounce,
// registered press/release pulses and (with AUTO_REPEAT_EN defined) an
// auto-repeat FSM that re-pulses press_o while the button stays held.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   pin_i      : raw asynchronous pin
//   level_o    : debounced level
//   press_o    : 1-cycle pulse on accepted rise (and on each repeat)
//   release_o  : 1-cycle pulse on accepted fall
// Macro: AUTO_REPEAT_EN
module btn_channel
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_RATE     = 32'd5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic              meta_q, sync_q;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              accept_c, rise_c, fall_c;

  // Synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
    end
  end

  // Debounce: any cycle of agreement restarts the window
  always_comb begin
    dcnt_d   = '0;
    level_d  = level_q;
    accept_c = 1'b0;
    if (sync_q != level_q) begin
      if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
        accept_c = 1'b1;
        level_d  = sync_q;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
  end

  assign rise_c = accept_c & sync_q;
  assign fall_c = accept_c & ~sync_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

  rpt_state_e        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rpt_pulse_c;

  // Repeat FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Repeat FSM next state; a release overrides any boundary in the same cycle
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    rpt_pulse_c = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if (rise_c) begin
          state_d = RPT_DELAY;
          rcnt_d  = '0;
        end
      end
      RPT_DELAY: begin
        if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
          rpt_pulse_c = 1'b1;
          state_d     = RPT_REPEAT;
          rcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (rcnt_q == RCNT_W'(REPEAT_RATE - 1)) begin
          rpt_pulse_c = 1'b1;
          rcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      default: begin
        state_d = RPT_IDLE;
        rcnt_d  = '0;
      end
    endcase
    if (fall_c) begin
      state_d     = RPT_IDLE;
      rcnt_d      = '0;
      rpt_pulse_c = 1'b0;
    end
  end

  assign press_d = rise_c | rpt_pulse_c;
`else
  // Repeat timing parameters have no effect in this build
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};

  assign press_d = rise_c;
`endif

  assign release_d = fall_c;

  // Debounce state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_input_array.sv
// N-channel button conditioning front end. Each channel is an independent
// btn_channel; any_press is the OR of all press pulses in the same cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn_in       : raw pins, bit i = channel i
//   btn_level    : debounced levels
//   btn_press    : 1-cycle press pulses (plus repeats with AUTO_REPEAT_EN)
//   btn_release  : 1-cycle release pulses
//   any_press    : |btn_press
// Macro: AUTO_REPEAT_EN enables per-channel auto-repeat.
module button_input_array
  import input_pkg::*;
#(
  parameter int unsigned N_CH            = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_RATE     = 32'd5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            any_press
);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pin_i     (btn_in[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_input_array.sv
// Directed bench for button_input_array (N_CH=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3). Expected pulse timing follows the
// build: with AUTO_REPEAT_EN, held buttons also re-pulse press.
module tb_button_input_array;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = 2 + DEB;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release;
  logic       any_press;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_input_array #(
    .N_CH            (4),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Is a press pulse expected d cycles after the initial accepted press?
  function automatic logic rpt_exp(input int d);
`ifdef AUTO_REPEAT_EN
    if (d == 0) return 1'b1;
    if (d >= RD && ((d - RD) % RR) == 0) return 1'b1;
    return 1'b0;
`else
    return (d == 0);
`endif
  endfunction

  task automatic test_reset();
    logic [12:0] exp_v, obs_v;
    logic [3:0]  el, ep, er;
    rst    = 1'b1;
    btn_in = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== 13'd0) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs_v, 13'd0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k >= LAT) ? 4'hF : 4'h0;
      ep = (k == LAT) ? 4'hF : 4'h0;
      er = 4'h0;
      exp_v = {el, ep, er, |ep};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
    btn_in = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k < LAT) ? 4'hF : 4'h0;
      ep = 4'h0;
      er = (k == LAT) ? 4'hF : 4'h0;
      exp_v = {el, ep, er, 1'b0};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_all_fall k=%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] obs_v;
    btn_in = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) btn_in = 4'b0000;
      tick();
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== 13'd0) begin
        bad++;
        $display("FAIL glitch k=%0d got=%b exp=%b", k, obs_v, 13'd0);
      end
    end
  endtask

  // Hold one channel for `hold` cycles after the rise, then release it
  task automatic test_hold(input string name, input logic [3:0] ch, input int hold,
                           input int tail);
    logic [12:0] exp_v, obs_v;
    logic [3:0]  el, ep, er;
    btn_in = ch;
    for (int k = 1; k <= hold; k++) begin
      tick();
      el = (k >= LAT) ? ch : 4'h0;
      ep = (k >= LAT && rpt_exp(k - LAT)) ? ch : 4'h0;
      er = 4'h0;
      exp_v = {el, ep, er, |ep};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL %s_held k=%0d got=%b exp=%b", name, k, obs_v, exp_v);
      end
    end
    btn_in = 4'h0;
    for (int k = 1; k <= tail; k++) begin
      tick();
      el = (k < LAT) ? ch : 4'h0;
      ep = (k < LAT && rpt_exp(hold - LAT + k)) ? ch : 4'h0;
      er = (k == LAT) ? ch : 4'h0;
      exp_v = {el, ep, er, |ep};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL %s_fall k=%0d got=%b exp=%b", name, k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_press_release();
    test_hold("press_release_ch2", 4'b0100, 20, 10);
  endtask

  task automatic test_simultaneous();
    test_hold("simultaneous_ch1_ch3", 4'b1010, 8, 8);
  endtask

  task automatic test_auto_repeat();
    // Held 30 cycles past the press pulse, then released; extra tail cycles
    // cover the repeat boundary that would fall just after the release.
    test_hold("auto_repeat_ch0", 4'b0001, LAT + 30, 15);
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp_v, obs_v;
    logic [3:0]  el, ep, er;
    btn_in = 4'b0010;
    // Four edges: sync high after edge 2, dcnt reaches 2 after edge 4
    for (int k = 1; k <= 4; k++) begin
      tick();
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== 13'd0) begin
        bad++;
        $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs_v, 13'd0);
      end
    end
    rst = 1'b1;
    tick();
    obs_v = {btn_level, btn_press, btn_release, any_press};
    total++;
    if (obs_v !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_rst got=%b exp=%b", obs_v, 13'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k >= LAT) ? 4'b0010 : 4'h0;
      ep = (k == LAT) ? 4'b0010 : 4'h0;
      er = 4'h0;
      exp_v = {el, ep, er, |ep};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
    btn_in = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k < LAT) ? 4'b0010 : 4'h0;
      er = (k == LAT) ? 4'b0010 : 4'h0;
      exp_v = {el, 4'h0, er, 1'b0};
      obs_v = {btn_level, btn_press, btn_release, any_press};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_fall k=%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'h0;
    test_reset();
    test_glitch();
    test_press_release();
    test_simultaneous();
    test_auto_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
